// File: rtl/mul_hilo_seq.sv
// mul_hilo_seq: operand sequencer and HI/LO result registers around an external
// combinational 32x32 signed multiplier.
`default_nettype none
`timescale 1ns/1ps

module mul_hilo_seq #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        cancel,
    input  logic        hi_wr,
    input  logic        lo_wr,
    input  logic [31:0] wr_data,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    input  logic [63:0] mul_product,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            x_q     <= 32'd0;
            y_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        // Register writes are locked out while a multiply owns HI/LO.
        if (!busy_q) begin
            if (hi_wr) hi_d = wr_data;
            if (lo_wr) lo_d = wr_data;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = op_a;
                    y_d     = op_b;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    state_d = (SETTLE_CYCLES == 1) ? S_CAPTURE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (!cancel) begin
                    hi_d   = mul_product[63:32];
                    lo_d   = mul_product[31:0];
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign mul_x = x_q;
    assign mul_y = y_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_hilo_seq.sv
// tb_mul_hilo_seq: scoreboard bench for mul_hilo_seq at settle times 2 (main), 1 and 4.
`default_nettype none
`timescale 1ns/1ps

module tb_mul_hilo_seq;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear, cancel, hi_wr, lo_wr, ideal0;
    logic [31:0] wr_data;
    logic        start_v [3];
    logic [31:0] a_v [3], b_v [3], mx_v [3], my_v [3], hi_v [3], lo_v [3];
    logic        busy_v [3], done_v [3];

    int          checks = 0;
    int          failures = 0;
    logic [63:0] q0 [$], q1 [$], q2 [$];

    function automatic logic [63:0] smul(input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        return sx * sy;
    endfunction

    // Instance 0 is the main DUT; 1 and 4 settle-cycle variants only see the timing test.
    // The model multiplier is correct only in the cycle before capture unless ideal0 is set.
    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int SC = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
            logic        act;
            logic [3:0]  k;
            logic [63:0] prod;

            always @(posedge clock) begin
                if (clear || (g == 0 && cancel)) begin
                    act <= 1'b0;
                    k   <= 4'd0;
                end else if (start_v[g]) begin
                    act <= 1'b1;
                    k   <= 4'd0;
                end else if (act) begin
                    k <= k + 4'd1;
                    if (k == 4'(SC - 1)) act <= 1'b0;
                end
            end

            always_comb begin
                prod = 64'hDEADBEEF_DEADBEEF;
                if ((g == 0 && ideal0) || (act && k == 4'(SC - 1)))
                    prod = smul(mx_v[g], my_v[g]);
            end

            mul_hilo_seq #(.SETTLE_CYCLES(SC)) u_dut (
                .clock       (clock),
                .clear       (clear),
                .start       (start_v[g]),
                .op_a        (a_v[g]),
                .op_b        (b_v[g]),
                .cancel      ((g == 0) ? cancel : 1'b0),
                .hi_wr       ((g == 0) ? hi_wr : 1'b0),
                .lo_wr       ((g == 0) ? lo_wr : 1'b0),
                .wr_data     (wr_data),
                .mul_x       (mx_v[g]),
                .mul_y       (my_v[g]),
                .mul_product (prod),
                .hi          (hi_v[g]),
                .lo          (lo_v[g]),
                .busy        (busy_v[g]),
                .done        (done_v[g])
            );
        end
    endgenerate

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mon(input int g);
        logic [63:0] e;
        logic        found;
        found = 1'b0;
        e     = '0;
        case (g)
            0: if (q0.size() > 0) begin e = q0.pop_front(); found = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); found = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); found = 1'b1; end
        endcase
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done dut%0d actual=done required=no_done", g);
        end else begin
            chk($sformatf("result_dut%0d", g), {hi_v[g], lo_v[g]}, e);
        end
    endtask

    initial begin
        clear = 1'b1; cancel = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0; ideal0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
        end

        fork
            forever begin
                @(negedge clock);
                for (int g = 0; g < 3; g++)
                    if (done_v[g]) mon(g);
            end
        join_none

        // Reset with garbage on the product bus
        tick(); tick();
        chk("reset_hilo", {hi_v[0], lo_v[0]}, 64'd0);
        chk("reset_busy_done", {62'd0, busy_v[0], done_v[0]}, 64'd0);
        chk("reset_xy", {mx_v[0], my_v[0]}, 64'd0);
        clear = 1'b0;
        tick();
        chk("post_reset_hilo", {hi_v[0], lo_v[0]}, 64'd0);

        // Basic 7 * -3
        ideal0 = 1'b1;
        start_v[0] = 1'b1; a_v[0] = 32'd7; b_v[0] = 32'hFFFFFFFD;
        q0.push_back(64'hFFFFFFFF_FFFFFFEB);
        tick();
        start_v[0] = 1'b0;
        chk("basic_e0_busy_done", {62'd0, busy_v[0], done_v[0]}, 64'd2);
        chk("basic_e0_xy", {mx_v[0], my_v[0]}, 64'h00000007_FFFFFFFD);
        tick();
        chk("basic_e1_busy_done", {62'd0, busy_v[0], done_v[0]}, 64'd2);
        tick();
        chk("basic_e2_busy_done", {62'd0, busy_v[0], done_v[0]}, 64'd1);
        tick();
        chk("basic_e3_done_clear", {63'd0, done_v[0]}, 64'd0);

        // Extreme operands, then back-to-back start in the done cycle
        start_v[0] = 1'b1; a_v[0] = 32'h80000000; b_v[0] = 32'h80000000;
        q0.push_back(64'h40000000_00000000);
        tick();
        start_v[0] = 1'b0;
        tick(); tick();
        chk("b2b_first_done", {63'd0, done_v[0]}, 64'd1);
        start_v[0] = 1'b1; a_v[0] = 32'hFFFFFFFF; b_v[0] = 32'd1;
        q0.push_back(64'hFFFFFFFF_FFFFFFFF);
        tick();
        start_v[0] = 1'b0;
        chk("b2b_e3_busy_done", {62'd0, busy_v[0], done_v[0]}, 64'd2);
        tick();
        chk("b2b_e4_done", {63'd0, done_v[0]}, 64'd0);
        tick();
        chk("b2b_e5_done", {63'd0, done_v[0]}, 64'd1);
        tick();

        // Settle timing with a product that is valid only in the cycle before capture
        ideal0 = 1'b0;
        start_v[0] = 1'b1; a_v[0] = 32'hFFFFFFFB; b_v[0] = 32'd100;
        start_v[1] = 1'b1; a_v[1] = 32'h00010000; b_v[1] = 32'h00010000;
        start_v[2] = 1'b1; a_v[2] = 32'h7FFFFFFF; b_v[2] = 32'h7FFFFFFF;
        q0.push_back(64'hFFFFFFFF_FFFFFE0C);
        q1.push_back(64'h00000001_00000000);
        q2.push_back(64'h3FFFFFFF_00000001);
        tick();
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("settle_done_pattern_e%0d", i),
                {61'd0, done_v[0], done_v[1], done_v[2]},
                {61'd0, (i == 2), (i == 1), (i == 4)});
        end
        ideal0 = 1'b1;

        // Cancel during SETTLE
        start_v[0] = 1'b1; a_v[0] = 32'd5; b_v[0] = 32'd6;
        tick();
        start_v[0] = 1'b0; cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel_busy_done", {62'd0, busy_v[0], done_v[0]}, 64'd0);
        tick(); tick();
        chk("cancel_hilo_kept", {hi_v[0], lo_v[0]}, 64'hFFFFFFFF_FFFFFE0C);

        // Start while busy is ignored
        start_v[0] = 1'b1; a_v[0] = 32'd2; b_v[0] = 32'd3;
        q0.push_back(64'd6);
        tick();
        a_v[0] = 32'd9; b_v[0] = 32'd9;
        tick();
        start_v[0] = 1'b0;
        chk("busy_start_xy", {mx_v[0], my_v[0]}, 64'h00000002_00000003);
        tick();
        chk("busy_start_done", {63'd0, done_v[0]}, 64'd1);
        tick();

        // MTHI in IDLE, MTLO while busy
        hi_wr = 1'b1; wr_data = 32'h12345678;
        tick();
        hi_wr = 1'b0;
        chk("mthi", {hi_v[0], lo_v[0]}, 64'h12345678_00000006);
        start_v[0] = 1'b1; a_v[0] = 32'd3; b_v[0] = 32'd4;
        q0.push_back(64'd12);
        tick();
        start_v[0] = 1'b0; lo_wr = 1'b1; wr_data = 32'hAAAA5555;
        tick();
        lo_wr = 1'b0;
        chk("mtlo_busy_ignored", {hi_v[0], lo_v[0]}, 64'h12345678_00000006);
        tick(); tick();

        // Cancel together with start in IDLE: start wins
        cancel = 1'b1; start_v[0] = 1'b1; a_v[0] = 32'hFFFFFFFF; b_v[0] = 32'hFFFFFFFF;
        q0.push_back(64'd1);
        tick();
        cancel = 1'b0; start_v[0] = 1'b0;
        chk("idle_cancel_start_busy", {63'd0, busy_v[0]}, 64'd1);
        tick(); tick(); tick();

        // Clear during SETTLE
        start_v[0] = 1'b1; a_v[0] = 32'd11; b_v[0] = 32'd11;
        tick();
        start_v[0] = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("midclear_hilo", {hi_v[0], lo_v[0]}, 64'd0);
        chk("midclear_busy_done", {62'd0, busy_v[0], done_v[0]}, 64'd0);
        chk("midclear_xy", {mx_v[0], my_v[0]}, 64'd0);
        tick(); tick(); tick();

        chk("drain_q0", 64'(q0.size()), 64'd0);
        chk("drain_q1", 64'(q1.size()), 64'd0);
        chk("drain_q2", 64'(q2.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
